// File: rtl/refill_read_arbiter.sv
// refill_read_arbiter
// Shares one AXI4 read channel between the ICache and DCache line-refill
// ports. Each grant issues one BEATS-long INCR burst of 32-bit beats. The
// beats are assembled into a line, which is returned to the winner with a
// one-cycle valid pulse.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   inst_ren_i/araddr_i  ICache refill request and address
//   inst_rvalid_o/rdata_o ICache line-ready pulse and line
//   data_ren_i/araddr_i  DCache refill request and address
//   data_rvalid_o/rdata_o DCache line-ready pulse and line
//   ar*                  AXI read address channel (master side)
//   r*                   AXI read data channel (master side)
module refill_read_arbiter #(
  parameter int unsigned BEATS   = 8,
  parameter logic [3:0]  INST_ID = 4'h0,
  parameter logic [3:0]  DATA_ID = 4'h1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_ren_i,
  input  logic [31:0]           inst_araddr_i,
  output logic                  inst_rvalid_o,
  output logic [32*BEATS-1:0]   inst_rdata_o,
  input  logic                  data_ren_i,
  input  logic [31:0]           data_araddr_i,
  output logic                  data_rvalid_o,
  output logic [32*BEATS-1:0]   data_rdata_o,
  output logic [3:0]            arid,
  output logic [31:0]           araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [3:0]            rid,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready
);

  localparam int unsigned LINE_W = 32 * BEATS;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_e;

  state_e              state_q;
  logic                grant_data_q;
  logic                last_data_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [LINE_W-1:0]   line_q;
  logic [LINE_W-1:0]   line_wr;
  logic                win_data;

  // Only one burst is ever outstanding, so id/resp/last carry no information.
  logic unused_inputs;
  assign unused_inputs = ^{rid, rresp, rlast,
                           inst_araddr_i[OFF_W-1:0], data_araddr_i[OFF_W-1:0]};

  // Burst shape is fixed: full line, 4-byte beats, incrementing.
  assign arlen   = 8'(BEATS - 1);
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

  // Ties go to the side that was not served last time.
  assign win_data = data_ren_i & (~inst_ren_i | ~last_data_q);

  // Current line buffer with the incoming beat merged into word cnt.
  always_comb begin
    line_wr = line_q;
    line_wr[32*cnt_q +: 32] = rdata;
  end

  // Arbitration / burst FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_data_q  <= 1'b0;
      last_data_q   <= 1'b0;
      cnt_q         <= '0;
      line_q        <= '0;
      arvalid       <= 1'b0;
      araddr        <= '0;
      arid          <= '0;
      rready        <= 1'b0;
      inst_rvalid_o <= 1'b0;
      data_rvalid_o <= 1'b0;
      inst_rdata_o  <= '0;
      data_rdata_o  <= '0;
    end else begin
      inst_rvalid_o <= 1'b0;
      data_rvalid_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (inst_ren_i | data_ren_i) begin
            grant_data_q <= win_data;
            araddr       <= {(win_data ? data_araddr_i[31:OFF_W] : inst_araddr_i[31:OFF_W]),
                             OFF_W'(0)};
            arid         <= win_data ? DATA_ID : INST_ID;
            cnt_q        <= '0;
            arvalid      <= 1'b1;
            state_q      <= ADDR;
          end
        end
        ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state_q <= DATA;
          end
        end
        DATA: begin
          // rready is held high for the whole DATA state.
          if (rvalid) begin
            line_q <= line_wr;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BEAT) begin
              rready  <= 1'b0;
              state_q <= DONE;
              if (grant_data_q) begin
                data_rvalid_o <= 1'b1;
                data_rdata_o  <= line_wr;
              end else begin
                inst_rvalid_o <= 1'b1;
                inst_rdata_o  <= line_wr;
              end
            end
          end
        end
        DONE: begin
          last_data_q <= grant_data_q;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_refill_read_arbiter.sv
// Testbench for refill_read_arbiter: AXI slave model with programmable stalls,
// a transaction-level arbiter model, directed vectors and random traffic.
module tb_refill_read_arbiter;

  localparam int unsigned BEATS = 8;
  localparam int unsigned LW    = 32 * BEATS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          inst_ren_i, data_ren_i;
  logic [31:0]   inst_araddr_i, data_araddr_i;
  logic          inst_rvalid_o, data_rvalid_o;
  logic [LW-1:0] inst_rdata_o, data_rdata_o;
  logic [3:0]    arid;
  logic [31:0]   araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid, arready;
  logic [3:0]    rid;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rlast, rvalid, rready;

  refill_read_arbiter #(.BEATS(BEATS), .INST_ID(4'h0), .DATA_ID(4'h1)) dut (
    .clk(clk), .rst(rst),
    .inst_ren_i(inst_ren_i), .inst_araddr_i(inst_araddr_i),
    .inst_rvalid_o(inst_rvalid_o), .inst_rdata_o(inst_rdata_o),
    .data_ren_i(data_ren_i), .data_araddr_i(data_araddr_i),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  int n_checks, n_fail, cyc;

  // Stimulus configuration
  bit tab_mode, rand_stall, auto_drop;
  int cfg_aw;
  int cfg_gap [BEATS];

  // Transaction-level model: who is served, when the pulse lands, which line
  bit          m_busy, m_win_data, m_last_data;
  int          m_free, m_grant, m_aw, m_pulse;
  logic [31:0] m_addr;
  int          b_gap [BEATS];

  // AXI slave state
  bit          s_burst;
  int          s_awcnt, s_idx, s_gap;
  logic [31:0] s_addr;
  logic [3:0]  s_id;
  logic        rready_prev;

  function automatic logic [31:0] beat_word(input logic [31:0] a, input int i, input bit tab);
    if (tab) return 32'(32'h11 * (i + 1));
    return (a + 32'(4 * i)) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic logic [LW-1:0] line_of(input logic [31:0] a, input bit tab);
    logic [LW-1:0] l;
    for (int i = 0; i < BEATS; i++) l[32*i +: 32] = beat_word(a, i, tab);
    return l;
  endfunction

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic slave();
    if (rst) begin
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
      s_burst = 1'b0; s_awcnt = 0; rready_prev = 1'b0;
      return;
    end
    if (arready) begin
      arready = 1'b0; s_burst = 1'b1; s_idx = 0; s_gap = 0; s_awcnt = 0;
    end else if (arvalid) begin
      if (s_awcnt >= m_aw) begin
        arready = 1'b1; s_addr = araddr; s_id = arid;
      end else s_awcnt++;
    end
    if (rvalid && rready_prev) begin
      rvalid = 1'b0; s_gap = b_gap[s_idx]; s_idx++;
    end
    if (s_burst) begin
      if (s_idx >= BEATS) begin
        s_burst = 1'b0; rvalid = 1'b0;
      end else if (s_gap > 0) begin
        s_gap--; rvalid = 1'b0;
      end else begin
        rvalid = 1'b1; rdata = beat_word(s_addr, s_idx, tab_mode);
        rid = s_id; rlast = (s_idx == BEATS - 1);
      end
    end
    rready_prev = rready;
  endtask

  // Per-cycle checks against the model, then slave and model advance.
  task automatic monitor();
    bit e_arv, e_rr, e_pi, e_pd;
    int gsum;
    logic [31:0] a;
    e_arv = m_busy && cyc >= m_grant + 1 && cyc <= m_grant + 1 + m_aw;
    e_rr  = m_busy && cyc >= m_grant + 2 + m_aw && cyc < m_pulse;
    e_pi  = m_busy && cyc == m_pulse && !m_win_data;
    e_pd  = m_busy && cyc == m_pulse && m_win_data;
    check("arvalid", LW'(arvalid), LW'(e_arv));
    check("rready", LW'(rready), LW'(e_rr));
    check("inst_rvalid_o", LW'(inst_rvalid_o), LW'(e_pi));
    check("data_rvalid_o", LW'(data_rvalid_o), LW'(e_pd));
    if (e_arv) begin
      check("araddr", LW'(araddr), LW'(m_addr));
      check("arid", LW'(arid), LW'(m_win_data ? 4'h1 : 4'h0));
      check("arlen", LW'(arlen), LW'(8'd7));
      check("arsize", LW'(arsize), LW'(3'b010));
      check("arburst", LW'(arburst), LW'(2'b01));
    end
    if (e_pi) check("inst_rdata_o", inst_rdata_o, line_of(m_addr, tab_mode));
    if (e_pd) check("data_rdata_o", data_rdata_o, line_of(m_addr, tab_mode));
    slave();
    if (rst) begin
      m_busy = 1'b0; m_last_data = 1'b0; m_free = cyc + 1;
    end else if (m_busy && cyc == m_pulse) begin
      m_busy = 1'b0; m_last_data = m_win_data; m_free = cyc + 1;
    end else if (!m_busy && cyc >= m_free && (inst_ren_i || data_ren_i)) begin
      m_win_data = data_ren_i && (!inst_ren_i || !m_last_data);
      a = m_win_data ? data_araddr_i : inst_araddr_i;
      m_addr = a & 32'hFFFF_FFE0;
      if (rand_stall) begin
        m_aw = int'($urandom_range(0, 3));
        for (int i = 0; i < BEATS; i++)
          b_gap[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      end else begin
        m_aw = cfg_aw;
        for (int i = 0; i < BEATS; i++) b_gap[i] = cfg_gap[i];
      end
      b_gap[BEATS-1] = 0;
      gsum = 0;
      for (int i = 0; i < BEATS; i++) gsum += b_gap[i];
      m_grant = cyc;
      m_pulse = cyc + 10 + m_aw + gsum;
      m_busy  = 1'b1;
    end
  endtask

  // One clock: check this cycle, advance, release a served requester in DONE.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    if (auto_drop && m_busy && cyc == m_pulse) begin
      if (m_win_data) data_ren_i = 1'b0;
      else            inst_ren_i = 1'b0;
    end
  endtask

  function automatic bit cond(input int w);
    case (w)
      0:       return arvalid;
      1:       return rready;
      default: return inst_rvalid_o | data_rvalid_o;
    endcase
  endfunction

  task automatic wait_for(input int w, input string name);
    int n;
    n = 0;
    while (!cond(w) && n < 80) begin tick(); n++; end
    check(name, LW'(cond(w)), LW'(1'b1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_busy || inst_ren_i || data_ren_i || cyc < m_free) && n < 200) begin tick(); n++; end
    check("drain", LW'(n < 200), LW'(1'b1));
  endtask

  task automatic reset_checks(input string tag);
    check({tag, " arvalid"}, LW'(arvalid), LW'(1'b0));
    check({tag, " rready"}, LW'(rready), LW'(1'b0));
    check({tag, " inst_rvalid_o"}, LW'(inst_rvalid_o), LW'(1'b0));
    check({tag, " data_rvalid_o"}, LW'(data_rvalid_o), LW'(1'b0));
    check({tag, " araddr"}, LW'(araddr), LW'(32'h0));
    check({tag, " arid"}, LW'(arid), LW'(4'h0));
    check({tag, " arlen"}, LW'(arlen), LW'(8'd7));
    check({tag, " arsize"}, LW'(arsize), LW'(3'b010));
    check({tag, " arburst"}, LW'(arburst), LW'(2'b01));
  endtask

  typedef struct {
    bit          ri, rd;
    logic [31:0] ai, ad;
    int          aw, g1, g4;
    bit          tab;
    logic [3:0]  e_id;
    logic [31:0] e_araddr;
    int          e_lat;
    logic [31:0] e_w0, e_w7;
  } vec_t;

  function automatic vec_t mk(input bit ri, input bit rd, input logic [31:0] ai,
                              input logic [31:0] ad, input int aw, input int g1,
                              input int g4, input bit tab, input logic [3:0] e_id,
                              input logic [31:0] e_araddr, input int e_lat,
                              input logic [31:0] e_w0, input logic [31:0] e_w7);
    vec_t v;
    v.ri = ri; v.rd = rd; v.ai = ai; v.ad = ad; v.aw = aw; v.g1 = g1; v.g4 = g4;
    v.tab = tab; v.e_id = e_id; v.e_araddr = e_araddr; v.e_lat = e_lat;
    v.e_w0 = e_w0; v.e_w7 = e_w7;
    return v;
  endfunction

  initial begin
    vec_t        vecs [6];
    vec_t        v;
    int          t0, prev, cnt;
    logic [LW-1:0] ln;

    n_checks = 0; n_fail = 0; cyc = 0;
    rst = 1'b1;
    inst_ren_i = 1'b0; data_ren_i = 1'b0; inst_araddr_i = '0; data_araddr_i = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    tab_mode = 1'b1; rand_stall = 1'b0; auto_drop = 1'b1; cfg_aw = 0;
    for (int i = 0; i < BEATS; i++) begin cfg_gap[i] = 0; b_gap[i] = 0; end
    m_busy = 1'b0; m_win_data = 1'b0; m_last_data = 1'b0;
    m_free = 0; m_grant = 0; m_aw = 0; m_pulse = 0; m_addr = '0;
    s_burst = 1'b0; s_awcnt = 0; s_idx = 0; s_gap = 0; s_addr = '0; s_id = '0;
    rready_prev = 1'b0;

    vecs[0] = mk(1, 1, 32'h1FC0_0024, 32'h8000_107F, 0, 0, 0, 1, 4'h1, 32'h8000_1060, 10,
                 32'h11, 32'h88);
    vecs[1] = mk(1, 0, 32'h1FC0_0024, 32'h0, 0, 0, 0, 1, 4'h0, 32'h1FC0_0020, 10,
                 32'h11, 32'h88);
    vecs[2] = mk(0, 1, 32'h0, 32'h0000_0ABC, 0, 0, 0, 0, 4'h1, 32'h0000_0AA0, 10,
                 beat_word(32'h0000_0AA0, 0, 0), beat_word(32'h0000_0AA0, 7, 0));
    vecs[3] = mk(1, 0, 32'h1FC0_0040, 32'h0, 3, 1, 1, 1, 4'h0, 32'h1FC0_0040, 15,
                 32'h11, 32'h88);
    vecs[4] = mk(1, 1, 32'h0000_5008, 32'hFFFF_FFFF, 1, 1, 0, 0, 4'h1, 32'hFFFF_FFE0, 12,
                 beat_word(32'hFFFF_FFE0, 0, 0), beat_word(32'hFFFF_FFE0, 7, 0));
    vecs[5] = mk(0, 1, 32'h0, 32'h0000_001F, 0, 0, 0, 1, 4'h1, 32'h0000_0000, 10,
                 32'h11, 32'h88);

    @(posedge clk); #1;
    repeat (3) tick();
    rst = 1'b0;
    reset_checks("reset");

    // Directed vectors
    for (int k = 0; k < 6; k++) begin
      v = vecs[k];
      tab_mode = v.tab; cfg_aw = v.aw;
      for (int i = 0; i < BEATS; i++) cfg_gap[i] = 0;
      cfg_gap[1] = v.g1; cfg_gap[4] = v.g4;
      inst_araddr_i = v.ai; data_araddr_i = v.ad;
      inst_ren_i = v.ri; data_ren_i = v.rd;
      t0 = cyc;
      wait_for(0, "vec arvalid timeout");
      check("vec arid", LW'(arid), LW'(v.e_id));
      check("vec araddr", LW'(araddr), LW'(v.e_araddr));
      wait_for(2, "vec pulse timeout");
      check("vec latency", LW'(32'(cyc - t0)), LW'(32'(v.e_lat)));
      check("vec winner", LW'(data_rvalid_o), LW'(v.e_id == 4'h1));
      ln = data_rvalid_o ? data_rdata_o : inst_rdata_o;
      check("vec word0", LW'(ln[31:0]), LW'(v.e_w0));
      check("vec word7", LW'(ln[LW-1 -: 32]), LW'(v.e_w7));
      drain();
    end

    // Ties held continuously from reset: data, inst, data, inst, 11 cycles apart
    rst = 1'b1; tick(); rst = 1'b0;
    reset_checks("tie reset");
    auto_drop = 1'b0; tab_mode = 1'b0; cfg_aw = 0;
    for (int i = 0; i < BEATS; i++) cfg_gap[i] = 0;
    inst_araddr_i = 32'h0000_1000; data_araddr_i = 32'h0000_2000;
    inst_ren_i = 1'b1; data_ren_i = 1'b1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_for(0, "tie arvalid timeout");
      check("tie arid", LW'(arid), LW'((k % 2 == 0) ? 4'h1 : 4'h0));
      wait_for(2, "tie pulse timeout");
      check("tie pulse side", LW'(data_rvalid_o), LW'(k % 2 == 0));
      if (k > 0) check("tie pulse spacing", LW'(32'(cyc - prev)), LW'(32'd11));
      prev = cyc;
      if (k == 3) begin inst_ren_i = 1'b0; data_ren_i = 1'b0; end
      tick();
    end
    auto_drop = 1'b1;
    drain();

    // Requester drops after beat 3: burst completes, one pulse, no new AR
    tab_mode = 1'b1;
    inst_araddr_i = 32'h0040_0104; inst_ren_i = 1'b1;
    wait_for(1, "drop rready timeout");
    repeat (3) tick();
    inst_ren_i = 1'b0;
    wait_for(2, "drop pulse timeout");
    check("drop inst pulse", LW'(inst_rvalid_o), LW'(1'b1));
    check("drop line", inst_rdata_o, line_of(32'h0040_0100, 1'b1));
    cnt = 0;
    repeat (20) begin tick(); if (arvalid || inst_rvalid_o) cnt++; end
    check("drop quiet after", LW'(32'(cnt)), LW'(32'd0));

    // Reset at beat 4, then a fresh request completes normally
    inst_araddr_i = 32'h0000_3000; inst_ren_i = 1'b1;
    wait_for(1, "rst rready timeout");
    repeat (3) tick();
    rst = 1'b1; inst_ren_i = 1'b0;
    tick();
    rst = 1'b0;
    reset_checks("midburst reset");
    cnt = 0;
    repeat (15) begin tick(); if (inst_rvalid_o || data_rvalid_o || arvalid) cnt++; end
    check("no pulse after reset", LW'(32'(cnt)), LW'(32'd0));
    tab_mode = 1'b0;
    data_araddr_i = 32'h1234_5678; data_ren_i = 1'b1;
    t0 = cyc;
    wait_for(2, "post reset pulse timeout");
    check("post reset latency", LW'(32'(cyc - t0)), LW'(32'd10));
    check("post reset line", data_rdata_o, line_of(32'h1234_5660, 1'b0));
    drain();

    // Random traffic with random slave stalls
    rand_stall = 1'b1;
    repeat (3000) begin
      if (!inst_ren_i && $urandom_range(0, 5) == 0) begin
        inst_araddr_i = $urandom(); inst_ren_i = 1'b1;
      end
      if (!data_ren_i && $urandom_range(0, 5) == 0) begin
        data_araddr_i = $urandom(); data_ren_i = 1'b1;
      end
      tick();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
